// File: rtl/inst_mem_port.sv
// inst_mem_port: fetch-side port with a direct-mapped one-word-per-line instruction cache.
module inst_mem_port #(
  parameter int          ENTRIES    = 16,
  parameter logic [31:0] RESET_INST = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic        INVALIDATE,
  input  logic        INST_RDEN,
  input  logic [31:0] INST_RIADDR,
  output logic        INST_RVALID,
  output logic [31:0] INST_ROADDR,
  output logic [31:0] INST_RDATA,
  output logic        MEM_WAIT,
  output logic        MEM_RDEN,
  output logic [31:0] MEM_RADDR,
  input  logic        MEM_RVALID,
  input  logic [31:0] MEM_RDATA
);
  localparam int IDX = $clog2(ENTRIES);
  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
  state_t             state;
  logic [ENTRIES-1:0] valid;
  logic [29-IDX:0]    tags [ENTRIES];
  logic [31:0]        data [ENTRIES];
  logic [IDX-1:0]     idx, fidx;
  logic               hit, accept, fill_done, unused_ok;
  assign unused_ok = ^INST_RIADDR[1:0];
  assign idx       = INST_RIADDR[IDX+1:2];
  // MEM_RADDR holds the miss address for the whole fill, so it doubles as the fill latch
  assign fidx      = MEM_RADDR[IDX+1:2];
  assign hit       = valid[idx] && tags[idx] == INST_RIADDR[31:IDX+2];
  assign accept    = INST_RDEN && !MEM_WAIT && !FLUSH && state == IDLE;
  assign fill_done = state != IDLE && MEM_RVALID;
  always_ff @(posedge CLK)
    if (fill_done) begin
      tags[fidx] <= MEM_RADDR[31:IDX+2];
      data[fidx] <= MEM_RDATA;
    end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state       <= IDLE;
      valid       <= '0;
      INST_RVALID <= 1'b0;
      INST_ROADDR <= '0;
      INST_RDATA  <= RESET_INST;
      MEM_WAIT    <= 1'b0;
      MEM_RDEN    <= 1'b0;
      MEM_RADDR   <= '0;
    end else begin
      INST_RVALID <= (accept && hit) || (!FLUSH && state == FILL && MEM_RVALID);
      if (accept && hit) begin
        INST_ROADDR <= {INST_RIADDR[31:2], 2'b00};
        INST_RDATA  <= data[idx];
      end else if (!FLUSH && state == FILL && MEM_RVALID) begin
        INST_ROADDR <= MEM_RADDR;
        INST_RDATA  <= MEM_RDATA;
      end
      if (INVALIDATE) valid <= '0;
      else if (fill_done) valid[fidx] <= 1'b1;
      if (accept && !hit) begin
        state     <= FILL;
        MEM_WAIT  <= 1'b1;
        MEM_RDEN  <= 1'b1;
        MEM_RADDR <= {INST_RIADDR[31:2], 2'b00};
      end else if (fill_done) begin
        state    <= IDLE;
        MEM_WAIT <= 1'b0;
        MEM_RDEN <= 1'b0;
      end else if (state == FILL && FLUSH) state <= DRAIN;
    end
endmodule

// File: tb/tb_inst_mem_port.sv
// tb_inst_mem_port: random fetch/memory traffic checked every cycle against a cache-level model.
module tb_inst_mem_port;
  logic        CLK, RST, FLUSH, INVALIDATE, INST_RDEN, MEM_RVALID;
  logic [31:0] INST_RIADDR, MEM_RDATA;
  logic        INST_RVALID, MEM_WAIT, MEM_RDEN;
  logic [31:0] INST_ROADDR, INST_RDATA, MEM_RADDR;
  int total = 0, bad = 0;
  logic chk_en = 0;
  int          m_state;
  logic [15:0] m_valid;
  logic [25:0] m_tag [16];
  logic [31:0] m_data [16];
  logic [31:0] m_addr, exp_roaddr, exp_rdata;
  logic        exp_rvalid;

  inst_mem_port #(.ENTRIES(16), .RESET_INST(32'h0000_0013)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .INVALIDATE(INVALIDATE),
    .INST_RDEN(INST_RDEN), .INST_RIADDR(INST_RIADDR), .INST_RVALID(INST_RVALID),
    .INST_ROADDR(INST_ROADDR), .INST_RDATA(INST_RDATA), .MEM_WAIT(MEM_WAIT),
    .MEM_RDEN(MEM_RDEN), .MEM_RADDR(MEM_RADDR), .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA));

  initial CLK = 0;
  always #5 CLK = ~CLK;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", n, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_valid = '0; m_addr = '0;
    exp_rvalid = 0; exp_roaddr = '0; exp_rdata = 32'h0000_0013;
  endtask

  // Cache seen as a table of (valid, tag, word) per index plus an outstanding-fill record
  task automatic model(input logic r, input logic [31:0] a, input logic f, input logic inv,
                       input logic mv, input logic [31:0] md);
    logic resp;
    logic [31:0] ra, rd;
    int i;
    resp = 0; ra = '0; rd = '0;
    if (m_state == 0) begin
      if (r && !f) begin
        i = int'(a[5:2]);
        if (m_valid[i] && m_tag[i] == a[31:6]) begin
          resp = 1; ra = {a[31:2], 2'b00}; rd = m_data[i];
        end else begin
          m_addr = {a[31:2], 2'b00}; m_state = 1;
        end
      end
    end else if (mv) begin
      i = int'(m_addr[5:2]);
      m_valid[i] = 1; m_tag[i] = m_addr[31:6]; m_data[i] = md;
      if (m_state == 1) begin resp = 1; ra = m_addr; rd = md; end
      m_state = 0;
    end else if (f && m_state == 1) m_state = 2;
    if (inv) m_valid = '0;
    exp_rvalid = resp && !f;
    if (exp_rvalid) begin exp_roaddr = ra; exp_rdata = rd; end
  endtask

  task automatic step(input logic r, input logic [31:0] a, input logic f, input logic inv,
                      input logic mv, input logic [31:0] md);
    INST_RDEN = r; INST_RIADDR = a; FLUSH = f; INVALIDATE = inv; MEM_RVALID = mv; MEM_RDATA = md;
    @(posedge CLK);
    model(r, a, f, inv, mv, md);
    @(negedge CLK);
  endtask

  task automatic idle();
    step(0, 32'h0, 0, 0, 0, 32'h0);
  endtask

  task automatic fill(input logic [31:0] a, input logic [31:0] d, input int dly);
    step(1, a, 0, 0, 0, 32'h0);
    repeat (dly) idle();
    step(0, 32'h0, 0, 0, 1, d);
  endtask

  always @(negedge CLK)
    if (chk_en) begin
      chk("rvalid", {31'b0, INST_RVALID}, {31'b0, exp_rvalid});
      chk("roaddr", INST_ROADDR, exp_roaddr);
      chk("rdata", INST_RDATA, exp_rdata);
      chk("wait", {31'b0, MEM_WAIT}, {31'b0, m_state != 0});
      chk("mem_rden", {31'b0, MEM_RDEN}, {31'b0, m_state != 0});
      if (m_state != 0) chk("mem_raddr", MEM_RADDR, m_addr);
    end

  initial begin
    int cnt;
    logic r, f, inv, mv;
    logic [31:0] a, md;
    RST = 1; FLUSH = 0; INVALIDATE = 0; INST_RDEN = 0; INST_RIADDR = 0; MEM_RVALID = 0; MEM_RDATA = 0;
    model_reset();
    #1;
    chk("rst_rdata", INST_RDATA, 32'h0000_0013);
    chk("rst_rvalid", {31'b0, INST_RVALID}, 32'h0);
    chk("rst_wait", {31'b0, MEM_WAIT}, 32'h0);
    chk("rst_raddr", MEM_RADDR, 32'h0);
    repeat (2) @(negedge CLK);
    RST = 0; chk_en = 1;
    // cold miss
    step(1, 32'h2000_0000, 0, 0, 0, 0);
    idle(); idle();
    chk("cold_wait", {31'b0, MEM_WAIT}, 32'h1);
    chk("cold_rden", {31'b0, MEM_RDEN}, 32'h1);
    chk("cold_raddr", MEM_RADDR, 32'h2000_0000);
    step(0, 0, 0, 0, 1, 32'h0010_0093);
    chk("cold_rvalid", {31'b0, INST_RVALID}, 32'h1);
    chk("cold_roaddr", INST_ROADDR, 32'h2000_0000);
    chk("cold_rdata", INST_RDATA, 32'h0010_0093);
    chk("cold_wait_off", {31'b0, MEM_WAIT}, 32'h0);
    // hit streaming
    for (int i = 1; i < 4; i++) fill(32'h2000_0000 + 32'(4 * i), 32'h0010_0093 + 32'(i), i);
    for (int i = 0; i < 4; i++) begin
      step(1, 32'h2000_0000 + 32'(4 * i) + 32'(i % 4 == 3), 0, 0, 0, 0);
      chk("hit_rvalid", {31'b0, INST_RVALID}, 32'h1);
      chk("hit_roaddr", INST_ROADDR, 32'h2000_0000 + 32'(4 * i));
      chk("hit_rdata", INST_RDATA, 32'h0010_0093 + 32'(i));
      chk("hit_rden", {31'b0, MEM_RDEN}, 32'h0);
    end
    // conflict on index 0
    step(1, 32'h2000_0040, 0, 0, 0, 0);
    chk("conf_miss", {31'b0, MEM_RDEN}, 32'h1);
    step(0, 0, 0, 0, 1, 32'h0040_0013);
    step(1, 32'h2000_0000, 0, 0, 0, 0);
    chk("conf_remiss", {31'b0, MEM_RDEN}, 32'h1);
    step(0, 0, 0, 0, 1, 32'h0010_0093);
    // flush during fill
    step(1, 32'h2000_0100, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("drain_wait", {31'b0, MEM_WAIT}, 32'h1);
    idle();
    step(0, 0, 0, 0, 1, 32'h1234_5678);
    chk("drain_norsp", {31'b0, INST_RVALID}, 32'h0);
    step(1, 32'h2000_0100, 0, 0, 0, 0);
    chk("drain_hit", {31'b0, INST_RVALID}, 32'h1);
    chk("drain_data", INST_RDATA, 32'h1234_5678);
    // invalidate
    step(0, 0, 0, 1, 0, 0);
    step(1, 32'h2000_0100, 0, 0, 0, 0);
    chk("inv_miss", {31'b0, MEM_RDEN}, 32'h1);
    step(0, 0, 0, 0, 1, 32'h1234_5678);
    // async reset in fill
    step(1, 32'h2000_0200, 0, 0, 0, 0);
    #2 RST = 1;
    #1;
    chk("arst_wait", {31'b0, MEM_WAIT}, 32'h0);
    chk("arst_rden", {31'b0, MEM_RDEN}, 32'h0);
    chk("arst_rdata", INST_RDATA, 32'h0000_0013);
    model_reset();
    repeat (2) @(negedge CLK);
    RST = 0;
    step(0, 0, 0, 0, 1, 32'hdead_beef);
    chk("arst_norsp", {31'b0, INST_RVALID}, 32'h0);
    step(1, 32'h2000_0200, 0, 0, 0, 0);
    chk("arst_nowrite", {31'b0, MEM_RDEN}, 32'h1);
    step(0, 0, 0, 0, 1, 32'h0000_0200);
    // random traffic
    cnt = 2;
    for (int c = 0; c < 4000; c++) begin
      r = $urandom_range(0, 3) != 0;
      f = $urandom_range(0, 9) == 0;
      inv = $urandom_range(0, 31) == 0;
      a = 32'h2000_0000 | (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
          | 32'($urandom_range(0, 3));
      md = $urandom;
      if (m_state != 0) begin
        mv = cnt == 0;
        cnt = mv ? int'($urandom_range(0, 4)) : cnt - 1;
      end else mv = $urandom_range(0, 15) == 0;
      step(r, a, f, inv, mv, md);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
